// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter that
// steers mux4_registered.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = $clog2(NUM_REQ);

  typedef logic [IDX_W-1:0]   req_idx_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // The index is exactly two bits wide, so the increment wraps 3 -> 0 by itself.
  function automatic req_idx_t rr_next(input req_idx_t ptr);
    return ptr + req_idx_t'(1);
  endfunction

  function automatic req_vec_t idx_onehot(input req_idx_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/ack/select bundle between the requesters, the arbiter and the
// downstream consumer of the registered mux output.
interface mux4_rr_arbiter_if;
  import mux4_arb_pkg::*;

  req_vec_t req;
  logic     out_ready;
  req_idx_t sel;
  req_vec_t ack;
  logic     out_valid;
  req_idx_t out_src;

  // Arbiter side.
  modport master (
    input  req,
    input  out_ready,
    output sel,
    output ack,
    output out_valid,
    output out_src
  );

  // Requester and downstream side.
  modport slave (
    output req,
    output out_ready,
    input  sel,
    input  ack,
    input  out_valid,
    input  out_src
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating-priority picker: the first asserted request at or after ptr,
// searching upward and wrapping from 3 to 0.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  req_vec_t req_i,
  input  req_idx_t ptr_i,
  output req_idx_t winner_o,
  output logic     any_o
);

  req_idx_t idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // branch. Otherwise an unassigned path infers a latch.
    winner_o = ptr_i;
    any_o    = |req_i;
    idx      = ptr_i;
    // The search runs from the farthest offset back to ptr itself, so the
    // nearest asserted request is the last one written and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr_i + req_idx_t'(k);
      if (req_i[idx]) begin
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded burst locking. It drives the mux4_registered
// select and tags the registered output with valid and source.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter  int BURST = 4,
  localparam int CNT_W = $clog2(BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  mux4_rr_arbiter_if.master      bus
);

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  arb_state_e       state_q, state_d;
  req_idx_t         ptr_q, ptr_d;
  req_idx_t         owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             out_valid_q;
  req_idx_t         out_src_q;

  req_idx_t         winner;
  logic             any_req;
  req_vec_t         ack_c;
  req_idx_t         sel_c;

  rr_pick4 u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  assign cnt_inc = cnt_q + ONE_C;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ack_c   = '0;
    sel_c   = ptr_q;

    if (!rst) begin
      sel_c = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.out_ready && any_req) begin
            ack_c = idx_onehot(winner);
            sel_c = winner;
            if (BURST == 1) begin
              ptr_d = rr_next(winner);
            end else begin
              state_d = LOCK;
              owner_d = winner;
              cnt_d   = ONE_C;
            end
          end
        end

        LOCK: begin
          sel_c = owner_q;
          if (!bus.req[owner_q]) begin
            // The owner has gone quiet. Spend one bubble cycle, then rotate past it.
            state_d = IDLE;
            ptr_d   = rr_next(owner_q);
          end else if (bus.out_ready) begin
            ack_c = idx_onehot(owner_q);
            cnt_d = cnt_inc;
            if (cnt_inc == BURST_C) begin
              state_d = IDLE;
              ptr_d   = rr_next(owner_q);
            end
          end
          // While the owner requests but out_ready is low, the lock stalls in place.
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      out_valid_q <= |ack_c;
      out_src_q   <= sel_c;
    end
  end

  assign bus.ack       = ack_c;
  assign bus.sel       = sel_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src   = out_src_q;

  ack_onehot_a : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(ack_c));

  ack_legal_a : assert property (@(posedge clk) disable iff (!rst)
    (ack_c != '0) |-> ((ack_c == idx_onehot(sel_c)) && ((ack_c & ~bus.req) == '0)));

  cnt_bound_a : assert property (@(posedge clk) disable iff (!rst)
    cnt_q <= BURST_C);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter. Stimulus queues the expected beats, and a
// monitor matches them against out_valid/out_src and a stand-in registered mux.
module tb_mux4_rr_arbiter;
  import mux4_arb_pkg::*;

  typedef struct {
    int unsigned u;
    int unsigned due;
    logic [1:0]  src;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  req_vec_t    req_v [2];
  logic        rdy_v [2];
  req_vec_t    ack_w [2];
  req_idx_t    sel_w [2];
  logic        ov_w  [2];
  req_idx_t    src_w [2];
  logic [7:0]  mux_q [2];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb [$];
  exp_t        mon_e;

  mux4_rr_arbiter_if bus4 ();
  mux4_rr_arbiter_if bus1 ();

  assign bus4.req       = req_v[0];
  assign bus4.out_ready = rdy_v[0];
  assign bus1.req       = req_v[1];
  assign bus1.out_ready = rdy_v[1];
  assign ack_w[0] = bus4.ack;       assign ack_w[1] = bus1.ack;
  assign sel_w[0] = bus4.sel;       assign sel_w[1] = bus1.sel;
  assign ov_w[0]  = bus4.out_valid; assign ov_w[1]  = bus1.out_valid;
  assign src_w[0] = bus4.out_src;   assign src_w[1] = bus1.out_src;

  mux4_rr_arbiter #(.BURST(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mux4_rr_arbiter #(.BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs in1..in4 carry A1..A4. This stands in for mux4_registered (no enable, no reset).
  function automatic logic [7:0] din(input logic [1:0] s);
    return 8'hA1 + 8'(s);
  endfunction

  always @(posedge clk) begin
    mux_q[0] <= din(sel_w[0]);
    mux_q[1] <= din(sel_w[1]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs and check the combinational ack/sel. An expected
  // ack queues the beat that must appear on the mux output one cycle later.
  task automatic step(input int u, input req_vec_t r, input logic rdy,
                      input req_vec_t exp_ack, input logic [1:0] exp_sel);
    exp_t e;
    @(negedge clk);
    req_v[u] = r;
    rdy_v[u] = rdy;
    #1;
    check($sformatf("ack u%0d", u), 32'(ack_w[u]), 32'(exp_ack));
    check($sformatf("sel u%0d", u), 32'(sel_w[u]), 32'(exp_sel));
    if (exp_ack != '0) begin
      e.u    = u;
      e.due  = cyc + 1;
      e.src  = exp_sel;
      e.data = din(exp_sel);
      sb.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #2;
    for (int u = 0; u < 2; u++) begin
      if (ov_w[u] === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected beat u%0d: out_src=%0d, expected no valid (cycle %0d)",
                   u, src_w[u], cyc);
        end else begin
          mon_e = sb.pop_front();
          check("beat unit", 32'(u), mon_e.u);
          check("beat latency", cyc, mon_e.due);
          check("out_src", 32'(src_w[u]), 32'(mon_e.src));
          check("mux data", 32'(mux_q[u]), 32'(mon_e.data));
        end
      end
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      total++;
      bad++;
      $display("FAIL missing beat u%0d: out_valid=0, expected src %0d (cycle %0d)",
               sb[0].u, sb[0].src, cyc);
      void'(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_v[0] = '0; req_v[1] = '0;
    rdy_v[0] = 1'b1; rdy_v[1] = 1'b1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset out_valid", 32'(ov_w[0]), 0);
    check("reset out_src", 32'(src_w[0]), 0);
    check("reset out_valid u1", 32'(ov_w[1]), 0);

    // Held in reset with ready high. Nothing may be granted.
    repeat (2) begin
      @(negedge clk);
      req_v[0] = 4'b0110;
      #1;
      check("ack in reset", 32'(ack_w[0]), 0);
      check("sel in reset", 32'(sel_w[0]), 0);
    end
    req_v[0] = '0;
    @(posedge clk);
    #3 rst = 1'b1;

    // Idle with no requests for five cycles.
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b0000, 1'b1, 4'b0000, 2'd0);
      check("idle out_valid", 32'(ov_w[0]), 0);
    end

    // All four requesting: four-beat bursts rotate 0,1,2,3, then wrap to 0.
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++) begin
        step(0, 4'b1111, 1'b1, idx_onehot(2'(g)), 2'(g));
      end
    end
    step(0, 4'b1111, 1'b1, 4'b0001, 2'd0);
    step(0, 4'b0000, 1'b1, 4'b0000, 2'd0);

    // Lock on 2, stall for three cycles at cnt=2, finish the burst, rotate to 3.
    step(0, 4'b1100, 1'b1, 4'b0100, 2'd2);
    step(0, 4'b1100, 1'b1, 4'b0100, 2'd2);
    for (int i = 0; i < 3; i++) step(0, 4'b1100, 1'b0, 4'b0000, 2'd2);
    step(0, 4'b1100, 1'b1, 4'b0100, 2'd2);
    step(0, 4'b1100, 1'b1, 4'b0100, 2'd2);
    step(0, 4'b1100, 1'b1, 4'b1000, 2'd3);
    step(0, 4'b0000, 1'b1, 4'b0000, 2'd3);

    // Owner 1 drops after one beat. Bubble, then ptr=2 passes idle 2 and picks 3.
    step(0, 4'b0010, 1'b1, 4'b0010, 2'd1);
    step(0, 4'b1001, 1'b1, 4'b0000, 2'd1);
    step(0, 4'b1001, 1'b1, 4'b1000, 2'd3);
    step(0, 4'b0000, 1'b1, 4'b0000, 2'd3);

    // Reset in the middle of a burst on 3.
    step(0, 4'b1000, 1'b1, 4'b1000, 2'd3);
    step(0, 4'b1000, 1'b1, 4'b1000, 2'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async out_valid drop", 32'(ov_w[0]), 0);
    check("ack under reset", 32'(ack_w[0]), 0);
    check("sel under reset", 32'(sel_w[0]), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    // A fresh lock must deliver a full four beats before ptr=0 favours requester 0.
    for (int i = 0; i < 4; i++) step(0, 4'b1000, 1'b1, 4'b1000, 2'd3);
    step(0, 4'b1001, 1'b1, 4'b0001, 2'd0);
    step(0, 4'b0000, 1'b1, 4'b0000, 2'd0);

    // BURST=1 instance with A1..A4 on the mux inputs: requesters 0 and 2 alternate.
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b0101, 1'b1, 4'b0001, 2'd0);
      step(1, 4'b0101, 1'b1, 4'b0100, 2'd2);
    end
    step(1, 4'b0101, 1'b0, 4'b0000, 2'd3);
    step(1, 4'b0000, 1'b1, 4'b0000, 2'd3);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
